// File: rtl/conv_row_scheduler.sv
// conv_row_scheduler: feeds a frame row by row to the 1-D conv engine and streams tagged results out.
module conv_row_scheduler #(
    parameter int NUM_ROWS = 32,
    parameter int TIMEOUT  = 100,
    parameter int N_OUT    = 30,
    parameter int RES_W    = 18
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic                    row_valid,
    output logic                    row_ready,
    input  logic [255:0]            row_data,
    output logic                    eng_start,
    output logic [255:0]            eng_row_data,
    input  logic                    eng_done,
    input  logic signed [RES_W-1:0] eng_result [N_OUT],
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [RES_W-1:0] res_data,
    output logic [4:0]              res_idx,
    output logic [5:0]              res_row,
    output logic                    res_last,
    output logic                    frame_done,
    output logic                    busy,
    output logic                    timeout_err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ACCEPT, ISSUE, BUSY, DRAIN, FINISH, ERR} state_t;

    state_t                  state, state_nx;
    logic [TW-1:0]           tcnt;
    logic signed [RES_W-1:0] rbuf [N_OUT];
    logic                    hs, row_end, last_row, tmo;

    assign hs       = state == DRAIN && res_ready;
    assign row_end  = hs && res_idx == 5'(N_OUT - 1);
    assign last_row = res_row == 6'(NUM_ROWS - 1);
    assign tmo      = tcnt == TW'(TIMEOUT - 1);

    always_comb begin
        state_nx   = state;
        row_ready  = state == ACCEPT;
        eng_start  = state == ISSUE;
        res_valid  = state == DRAIN;
        res_data   = state == DRAIN ? rbuf[res_idx] : '0;
        res_last   = state == DRAIN && last_row && res_idx == 5'(N_OUT - 1);
        frame_done = state == FINISH;
        busy       = state != IDLE;
        case (state)
            IDLE:    state_nx = frame_start ? ACCEPT : IDLE;
            ACCEPT:  state_nx = row_valid ? ISSUE : ACCEPT;
            ISSUE:   state_nx = BUSY;
            BUSY:    state_nx = eng_done ? DRAIN : tmo ? ERR : BUSY;
            DRAIN:   state_nx = row_end ? (last_row ? FINISH : ACCEPT) : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            tcnt         <= '0;
            eng_row_data <= '0;
            res_idx      <= '0;
            res_row      <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state <= state_nx;
            tcnt  <= state == BUSY ? tcnt + TW'(1) : '0;
            if (state == IDLE && frame_start) begin
                res_row     <= '0;
                timeout_err <= 1'b0;
            end
            if (state == ACCEPT && row_valid)
                eng_row_data <= row_data;
            if (state == BUSY && eng_done)
                res_idx <= '0;
            // Flag is raised on the transition into ERR so it is visible in the ERR cycle itself.
            if (state == BUSY && !eng_done && tmo)
                timeout_err <= 1'b1;
            if (hs)
                res_idx <= row_end ? 5'd0 : res_idx + 5'd1;
            if (row_end && !last_row)
                res_row <= res_row + 6'd1;
        end
    end

    // Capture buffer needs no reset: res_data is gated to zero outside DRAIN.
    always_ff @(posedge clk)
        if (state == BUSY && eng_done)
            rbuf <= eng_result;
endmodule

// File: tb/tb_conv_row_scheduler.sv
// tb_conv_row_scheduler: table-driven frame scenarios plus hand-written reset/ignore sequences.
module tb_conv_row_scheduler;
    localparam int NR = 2;
    localparam int TO = 100;
    localparam int NO = 30;

    logic clk = 0, rst = 1, frame_start = 0, row_valid = 0, res_ready = 0;
    logic row_ready, eng_start, eng_done, res_valid, res_last, frame_done, busy, timeout_err;
    logic [255:0] row_data = '0, eng_row_data;
    logic signed [17:0] eng_result [NO];
    logic signed [17:0] res_data;
    logic [4:0] res_idx;
    logic [5:0] res_row;

    int n_cmp = 0, n_bad = 0;
    int stub_lat = 0, stub_cnt = 0, stub_base = 0, stub_n = 0, n_starts = 0;
    logic stub_clr = 0, extra_done = 0;

    typedef struct {
        int         lat;
        logic [3:0] rp;
        bit         inj;
        int         words;
        bit         err;
        int         starts;
    } vec_t;

    vec_t tbl[7];

    conv_row_scheduler #(.NUM_ROWS(NR), .TIMEOUT(TO), .N_OUT(NO), .RES_W(18)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .row_valid(row_valid),
        .row_ready(row_ready), .row_data(row_data), .eng_start(eng_start),
        .eng_row_data(eng_row_data), .eng_done(eng_done), .eng_result(eng_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_idx(res_idx), .res_row(res_row), .res_last(res_last),
        .frame_done(frame_done), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Engine stub: eng_done fires stub_lat cycles after the start pulse; 0 means never.
    always @(posedge clk) begin
        if (stub_clr) stub_n <= 0;
        if (eng_start) begin
            stub_cnt  <= stub_lat;
            stub_base <= 100 * stub_n;
            stub_n    <= stub_n + 1;
            n_starts  <= n_starts + 1;
        end else if (stub_cnt > 0)
            stub_cnt <= stub_cnt - 1;
    end

    assign eng_done = (stub_cnt == 1) | extra_done;

    always_comb
        for (int k = 0; k < NO; k++) eng_result[k] = 18'(stub_base + k);

    function automatic logic [255:0] pat(input int r);
        return {32{8'(r * 37 + 5)}};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v);
        int cyc, s_cyc, last_hs, words, fd, st0, n_acc, n_iss, erow, eidx;
        logic stalled, prev_done, prev_err;
        logic [30:0] snap;
        s_cyc = -1000; last_hs = -1000; words = 0; fd = 0; n_acc = 0; n_iss = 0;
        erow = 0; eidx = 0; stalled = 0; prev_done = 0; prev_err = 0; snap = '0;
        stub_lat = v.lat;
        st0 = n_starts;
        frame_start = 1; stub_clr = 1;
        @(negedge clk);
        frame_start = 0; stub_clr = 0;
        check("err_clear", timeout_err, 0);
        check("busy_on", busy, 1);
        row_valid = 1;
        for (cyc = 1; cyc < 3000 && busy; cyc++) begin
            if (eng_start) begin
                check("eng_row_data", eng_row_data == pat(n_iss), 1);
                n_iss++;
                s_cyc = cyc;
            end
            if (prev_done) check("first_valid", res_valid, 1);
            prev_done = stub_cnt == 1 && !timeout_err;
            if (timeout_err && !prev_err) check("tmo_cycle", cyc - s_cyc, TO + 1);
            prev_err = timeout_err;
            if (stalled) check("stall_hold", {res_valid, res_last, res_row, res_idx, res_data}, snap);
            res_ready = v.rp[cyc % 4];
            if (res_valid && res_ready) begin
                check("word", {res_row, res_idx, res_data, res_last},
                      {6'(erow), 5'(eidx), 18'(100 * erow + eidx), erow == NR - 1 && eidx == NO - 1});
                if (erow == NR - 1 && eidx == NO - 1) last_hs = cyc;
                words++;
                eidx = eidx == NO - 1 ? 0 : eidx + 1;
                if (eidx == 0) erow++;
            end
            stalled = res_valid && !res_ready;
            snap = {res_valid, res_last, res_row, res_idx, res_data};
            if (frame_done) begin
                fd++;
                check("frame_done_cycle", cyc, last_hs + 1);
            end
            row_data = pat(n_acc);
            if (row_ready && row_valid) n_acc++;
            frame_start = v.inj && n_iss == 1 && cyc == s_cyc + 5;
            extra_done  = v.inj && words == 5;
            @(negedge clk);
        end
        frame_start = 0; extra_done = 0; row_valid = 0; res_ready = 0;
        check("frame_bound", busy, 0);
        check("words", words, v.words);
        check("timeout_err", timeout_err, v.err);
        check("eng_starts", n_starts - st0, v.starts);
        check("frame_done_cnt", fd, v.err ? 0 : 1);
    endtask

    initial begin
        int hs, fd, st0;
        tbl[0] = '{66,  4'b1111, 0, 60, 0, 2};
        tbl[1] = '{66,  4'b1001, 0, 60, 0, 2};
        tbl[2] = '{100, 4'b1111, 0, 60, 0, 2};
        tbl[3] = '{0,   4'b1111, 0, 0,  1, 1};
        tbl[4] = '{66,  4'b1111, 0, 60, 0, 2};
        tbl[5] = '{1,   4'b1111, 0, 60, 0, 2};
        tbl[6] = '{66,  4'b1111, 1, 60, 0, 2};
        repeat (3) @(negedge clk);
        check("rst_ctl", {row_ready, eng_start, res_valid, res_last, frame_done, busy, timeout_err}, 0);
        check("rst_row_data", eng_row_data == '0, 1);
        check("rst_res", {res_data, res_idx, res_row}, 0);
        rst = 0;
        row_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_row_ready", {row_ready, busy}, 0);
        end
        row_valid = 0;
        foreach (tbl[i]) run_frame(tbl[i]);
        stub_lat = 66; hs = 0;
        frame_start = 1; stub_clr = 1;
        @(negedge clk);
        frame_start = 0; stub_clr = 0; row_valid = 1; res_ready = 1; row_data = pat(0);
        for (int c = 0; c < 1000 && !(res_valid && hs == 42); c++) begin
            if (res_valid) hs++;
            @(negedge clk);
        end
        check("pre_rst_pos", {res_valid, res_row, res_idx}, {1'b1, 6'd1, 5'd12});
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("mid_rst_ctl", {row_ready, eng_start, res_valid, res_last, frame_done, busy, timeout_err}, 0);
        check("mid_rst_res", {res_data, res_idx, res_row}, 0);
        check("mid_rst_row_data", eng_row_data == '0, 1);
        st0 = n_starts; fd = 0;
        repeat (200) begin
            @(negedge clk);
            if (frame_done) fd++;
        end
        check("post_rst_frame_done", fd, 0);
        check("post_rst_starts", n_starts - st0, 0);
        check("post_rst_idle", busy, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/conv_row_scheduler.md
# conv_row_scheduler

Sequencing controller that runs a whole frame through the single-row 1-D convolution engine. It accepts NUM_ROWS packed pixel rows over a valid/ready input stream. For each row it issues one engine run and waits for completion, with a timeout guard. It captures the 30 results and streams them out one per handshake, tagged with row/index/last. It sits between the frame fetch logic and the convolution engine and is the only block that drives the engine's start and row inputs.

## Interface
- NUM_ROWS, 32, rows per frame (1..64)
- TIMEOUT, 100, max BUSY cycles to wait for eng_done before declaring error (engine nominal run is 66 cycles)
- N_OUT, 30, results per row (fixed by engine)
- RES_W, 18, result width, signed

Ports:
- clk  in  1  clock; single clock domain, rising edge
- rst  in  1  reset, synchronous, active-high
- frame_start  in  1  begin a frame (sampled in IDLE only)
- row_valid  in  1  input row available
- row_ready  out  1  scheduler accepts row
- row_data  in  256  32 signed 8-bit pixels, pixel i at [8i+:8]
- eng_start  out  1  one-cycle start pulse to engine
- eng_row_data  out  256  row to engine, held stable from ISSUE until next row accept
- eng_done  in  1  engine completion pulse
- eng_result  in  18 x [0:29]  signed engine results, valid on eng_done cycle
- res_valid  out  1  result word valid
- res_ready  in  1  downstream accepts result
- res_data  out  18  signed result
- res_idx  out  5  result index 0..29 within row
- res_row  out  6  row index 0..NUM_ROWS-1
- res_last  out  1  high on final word of frame (row NUM_ROWS-1, idx 29)
- frame_done  out  1  one-cycle pulse after last word transferred
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky error; cleared by accepted frame_start or rst

## Operation
- States: IDLE, ACCEPT, ISSUE, BUSY, DRAIN, FINISH, ERR.
- IDLE: row_ready=0. If frame_start=1, go to ACCEPT, set row_cnt=0 and clear timeout_err.
- ACCEPT: row_ready=1. On row_valid&&row_ready, latch row_data into eng_row_data and go to ISSUE.
- ISSUE: eng_start=1 for exactly this cycle. Clear the timeout counter and go to BUSY.
- BUSY: the timeout counter increments each cycle.
  - If eng_done=1, copy eng_result into the 30-entry capture buffer, set res_idx=0 and go to DRAIN.
  - Otherwise, when the counter reaches TIMEOUT-1, go to ERR.
- DRAIN: res_valid=1, res_data=buf[res_idx], res_row=row_cnt.
  - On a res handshake, res_idx increments.
  - A handshake at res_idx=29 goes to FINISH if row_cnt=NUM_ROWS-1. Otherwise row_cnt increments and the block goes to ACCEPT.
- FINISH: frame_done=1 for one cycle, then go to IDLE.
- ERR: set timeout_err=1 for one cycle, then go to IDLE. Partial frame results already streamed are not retracted.
- Results pass through unmodified. No arithmetic, saturation or sign change in this block.

Boundary rules:
- frame_start outside IDLE is ignored.
- eng_done outside BUSY is ignored.
- row_valid outside ACCEPT is not consumed.
- eng_done on the same cycle the counter hits TIMEOUT-1: eng_done wins and the block goes to DRAIN.
- res_ready low holds res_valid, res_data, res_idx, res_row and res_last stable. res_valid is never withdrawn without a handshake.
- rst mid-frame aborts immediately. No frame_done and no eng_start are issued after reset.

## Timing
- Reset values:
  - state=IDLE.
  - row_ready, eng_start, res_valid, res_last, frame_done, busy and timeout_err are 0.
  - eng_row_data, res_data, res_idx and res_row are 0.
- Row accepted at cycle T: eng_start=1 at T+1, BUSY from T+2.
- eng_done at cycle D: first res_valid=1 at D+1.
- With res_ready held at 1, a row drains in 30 cycles. row_ready returns at the cycle after the idx-29 handshake.
- Per-row cost with an always-ready sink and a 66-cycle engine: 1 (ACCEPT) + 1 (ISSUE) + engine latency + 30 drain cycles.
- frame_done is asserted on the cycle after the last handshake.
- Timeout: ERR is entered TIMEOUT cycles after the first BUSY cycle if no eng_done arrives.

## Test plan
- Single frame, NUM_ROWS=2, bench engine stub returns result[k]=100*row+k after 66 cycles, res_ready=1 → 60 words in order: row0 0..29, row1 100..129. res_last only on the 60th word; frame_done one cycle later; eng_start pulsed exactly twice.
- Backpressure: res_ready toggled 1,0,0,1 repeating → every word delivered once, no drops or duplicates. Outputs are stable while stalled.
- Timeout: stub never asserts eng_done, TIMEOUT=100 → timeout_err=1 at 100 cycles after BUSY entry and state returns to IDLE. A subsequent frame_start clears timeout_err and the frame runs normally.
- Tie case: stub asserts eng_done exactly at counter=TIMEOUT-1 → results drain and timeout_err stays 0.
- Ignored inputs:
  - frame_start pulsed during BUSY, and eng_done pulsed during DRAIN → no state change, no extra eng_start.
  - row_valid=1 in IDLE → row_ready stays 0.
- Reset mid-DRAIN of row 1 at res_idx=12 → next cycle all outputs are at their reset values, busy=0, and frame_done is never asserted.
